// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit
// Central stall, flush and forwarding controller for the five-stage pipeline.
// It arbitrates cache waits, halt, branch mispredicts, load-use hazards and
// fetch misses into one stall code plus flush strobes and a PC enable. It also
// produces the operand forwarding selects and counts cycles where the PC is held.

module pipeline_hazard_unit (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic [4:0]  ifid_rs,
  input  logic [4:0]  ifid_rt,
  input  logic        ifid_uses_rt,
  input  logic        idex_RegWr,
  input  logic        idex_DataRead,
  input  logic [4:0]  idex_wsel,
  input  logic        exmem_RegWr,
  input  logic        exmem_DataRead,
  input  logic        exmem_DataWrite,
  input  logic [4:0]  exmem_wsel,
  input  logic        ex_mispredict,
  input  logic        memwb_Halt,
  output logic [2:0]  stall,
  output logic        pc_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        fwd_exmem_a,
  output logic        fwd_memwb_a,
  output logic        fwd_exmem_b,
  output logic        fwd_memwb_b,
  output logic        halted,
  output logic [31:0] stall_count
);

  localparam logic [2:0] NO_STALL   = 3'd0;
  localparam logic [2:0] IFID_STALL = 3'd1;
  localparam logic [2:0] FULL_STALL = 3'd3;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        ihitSeen_q, ihitSeen_d;
  logic [31:0] stallCount_q, stallCount_d;

  logic dmiss;
  logic lduse;
  logic ifetchOk;
  logic fwdExA, fwdMemA, fwdExB, fwdMemB;

  // Hazard terms shared by the priority chain; a fetch is good if the icache
  // hits now or hit earlier while the PC was being held.
  always_comb begin
    dmiss    = (exmem_DataRead | exmem_DataWrite) & ~dhit;
    lduse    = idex_DataRead & (idex_wsel != 5'd0) &
               ((idex_wsel == ifid_rs) | (ifid_uses_rt & (idex_wsel == ifid_rt)));
    ifetchOk = ihit | ihitSeen_q;
  end

  // Register state: state machine, remembered icache hit and stall counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= RUN;
      ihitSeen_q   <= 1'b0;
      stallCount_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      ihitSeen_q   <= ihitSeen_d;
      stallCount_q <= stallCount_d;
    end
  end

  // Priority chain choosing stall code, PC enable, flushes and next state.
  // DWAIT only records that a data miss is outstanding; the outputs follow the
  // live dmiss input, so leaving DWAIT simply happens once dmiss drops.
  always_comb begin
    stall      = NO_STALL;
    pc_en      = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    halted     = 1'b0;
    state_d    = state_q;
    if (RST) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_d    = RUN;
    end else if (state_q == HALTED) begin
      stall  = FULL_STALL;
      halted = 1'b1;
    end else if (memwb_Halt) begin
      stall   = FULL_STALL;
      state_d = HALTED;
    end else if (dmiss) begin
      stall   = FULL_STALL;
      state_d = DWAIT;
    end else begin
      state_d = RUN;
      if (ex_mispredict) begin
        pc_en      = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (lduse) begin
        stall      = IFID_STALL;
        idex_flush = 1'b1;
      end else if (!ifetchOk) begin
        ifid_flush = 1'b1;
      end else begin
        pc_en = 1'b1;
      end
    end
  end

  // Operand forwarding: the younger producer in EX wins over MEM, and register
  // zero never forwards. Not gated by stalls, only forced low during reset.
  always_comb begin
    fwdExA  = idex_RegWr & (idex_wsel != 5'd0) & (idex_wsel == ifid_rs);
    fwdExB  = idex_RegWr & (idex_wsel != 5'd0) & (idex_wsel == ifid_rt);
    fwdMemA = exmem_RegWr & (exmem_wsel != 5'd0) & (exmem_wsel == ifid_rs) & ~fwdExA;
    fwdMemB = exmem_RegWr & (exmem_wsel != 5'd0) & (exmem_wsel == ifid_rt) & ~fwdExB;
    fwd_exmem_a = fwdExA  & ~RST;
    fwd_memwb_a = fwdMemA & ~RST;
    fwd_exmem_b = fwdExB  & ~RST;
    fwd_memwb_b = fwdMemB & ~RST;
  end

  // Next value of the retained icache hit and the saturating stall counter.
  // Both are frozen once halted so the counter reflects only useful stalls.
  always_comb begin
    ihitSeen_d   = ihitSeen_q;
    stallCount_d = stallCount_q;
    if (pc_en) begin
      ihitSeen_d = 1'b0;
    end else if (ihit && (state_q != HALTED)) begin
      ihitSeen_d = 1'b1;
    end
    if (!pc_en && (state_q != HALTED) && (stallCount_q != 32'hFFFF_FFFF)) begin
      stallCount_d = stallCount_q + 32'd1;
    end
  end

  assign stall_count = stallCount_q;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// tb_pipeline_hazard_unit
// Directed scenarios plus randomized traffic for the hazard unit, checked every
// cycle against a behavioural model built from the hazard rules.

module tb_pipeline_hazard_unit;

  logic        CLK;
  logic        RST;
  logic        ihit, dhit;
  logic [4:0]  ifid_rs, ifid_rt;
  logic        ifid_uses_rt;
  logic        idex_RegWr, idex_DataRead;
  logic [4:0]  idex_wsel;
  logic        exmem_RegWr, exmem_DataRead, exmem_DataWrite;
  logic [4:0]  exmem_wsel;
  logic        ex_mispredict, memwb_Halt;
  logic [2:0]  stall;
  logic        pc_en, ifid_flush, idex_flush;
  logic        fwd_exmem_a, fwd_memwb_a, fwd_exmem_b, fwd_memwb_b;
  logic        halted;
  logic [31:0] stall_count;

  int checkCount = 0;
  int errorCount = 0;

  // Reference model state: halt lock, remembered fetch, stall cycle total.
  bit          mHalted = 0;
  bit          mSeen   = 0;
  longint      mCount  = 0;
  // Expected outputs of the current cycle.
  int          eStall;
  bit          ePc, eIfFl, eIdFl, eHalted;
  bit          eFxA, eFmA, eFxB, eFmB;

  pipeline_hazard_unit dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .idex_RegWr(idex_RegWr), .idex_DataRead(idex_DataRead), .idex_wsel(idex_wsel),
    .exmem_RegWr(exmem_RegWr), .exmem_DataRead(exmem_DataRead),
    .exmem_DataWrite(exmem_DataWrite), .exmem_wsel(exmem_wsel),
    .ex_mispredict(ex_mispredict), .memwb_Halt(memwb_Halt),
    .stall(stall), .pc_en(pc_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .fwd_exmem_a(fwd_exmem_a), .fwd_memwb_a(fwd_memwb_a),
    .fwd_exmem_b(fwd_exmem_b), .fwd_memwb_b(fwd_memwb_b),
    .halted(halted), .stall_count(stall_count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic clearInputs();
    RST = 0; ihit = 0; dhit = 0; ifid_rs = 0; ifid_rt = 0; ifid_uses_rt = 0;
    idex_RegWr = 0; idex_DataRead = 0; idex_wsel = 0;
    exmem_RegWr = 0; exmem_DataRead = 0; exmem_DataWrite = 0; exmem_wsel = 0;
    ex_mispredict = 0; memwb_Halt = 0;
  endtask

  task automatic applyStimulus(input bit allowReset, input bit allowHalt);
    RST             = allowReset && ($urandom_range(0, 39) == 0);
    ihit            = ($urandom_range(0, 3) != 0);
    dhit            = $urandom_range(0, 1) != 0;
    ifid_rs         = 5'($urandom_range(0, 7));
    ifid_rt         = 5'($urandom_range(0, 7));
    ifid_uses_rt    = $urandom_range(0, 1) != 0;
    idex_RegWr      = $urandom_range(0, 1) != 0;
    idex_DataRead   = ($urandom_range(0, 2) == 0);
    idex_wsel       = 5'($urandom_range(0, 7));
    exmem_RegWr     = $urandom_range(0, 1) != 0;
    exmem_DataRead  = ($urandom_range(0, 4) == 0);
    exmem_DataWrite = ($urandom_range(0, 6) == 0);
    exmem_wsel      = 5'($urandom_range(0, 7));
    ex_mispredict   = ($urandom_range(0, 7) == 0);
    memwb_Halt      = allowHalt && ($urandom_range(0, 59) == 0);
  endtask

  // Work out the expected outputs from the hazard rules and compare them all.
  task automatic checkModel();
    int  rs, rt, exd, memd;
    bit  missing, useHazard;
    rs = int'(ifid_rs); rt = int'(ifid_rt);
    exd = int'(idex_wsel); memd = int'(exmem_wsel);
    missing   = (exmem_DataRead || exmem_DataWrite) && !dhit;
    useHazard = idex_DataRead && exd != 0 &&
                (exd == rs || (ifid_uses_rt && exd == rt));
    eStall = 0; ePc = 0; eIfFl = 0; eIdFl = 0; eHalted = 0;
    eFxA = 0; eFmA = 0; eFxB = 0; eFmB = 0;
    if (RST) begin
      eIfFl = 1; eIdFl = 1;
    end else begin
      eFxA = idex_RegWr && exd != 0 && exd == rs;
      eFxB = idex_RegWr && exd != 0 && exd == rt;
      eFmA = !eFxA && exmem_RegWr && memd != 0 && memd == rs;
      eFmB = !eFxB && exmem_RegWr && memd != 0 && memd == rt;
      if (mHalted) begin
        eStall = 3; eHalted = 1;
      end else if (memwb_Halt || missing) begin
        eStall = 3;
      end else if (ex_mispredict) begin
        ePc = 1; eIfFl = 1; eIdFl = 1;
      end else if (useHazard) begin
        eStall = 1; eIdFl = 1;
      end else if (!(ihit || mSeen)) begin
        eIfFl = 1;
      end else begin
        ePc = 1;
      end
    end
    checkOutput("stall",       32'(stall),       32'(eStall));
    checkOutput("pc_en",       32'(pc_en),       32'(ePc));
    checkOutput("ifid_flush",  32'(ifid_flush),  32'(eIfFl));
    checkOutput("idex_flush",  32'(idex_flush),  32'(eIdFl));
    checkOutput("halted",      32'(halted),      32'(eHalted));
    checkOutput("fwd_exmem_a", 32'(fwd_exmem_a), 32'(eFxA));
    checkOutput("fwd_memwb_a", 32'(fwd_memwb_a), 32'(eFmA));
    checkOutput("fwd_exmem_b", 32'(fwd_exmem_b), 32'(eFxB));
    checkOutput("fwd_memwb_b", 32'(fwd_memwb_b), 32'(eFmB));
    checkOutput("stall_count", stall_count,      32'(mCount));
  endtask

  // Advance the model across the clock edge, then move to the next cycle.
  task automatic endCycle();
    if (RST) begin
      mHalted = 0; mSeen = 0; mCount = 0;
    end else begin
      if (!ePc && !mHalted && mCount < 64'hFFFF_FFFF) mCount++;
      if (ePc) mSeen = 0;
      else if (ihit && !mHalted) mSeen = 1;
      if (!mHalted && memwb_Halt) mHalted = 1;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic stepCycle();
    #4;
    checkModel();
    endCycle();
  endtask

  longint frozenCount;

  initial begin
    clearInputs();
    RST = 1;
    @(posedge CLK);
    #1;

    // Reset with every input high for two cycles.
    RST = 1; ihit = 1; dhit = 1; ifid_rs = 5'h1f; ifid_rt = 5'h1f; ifid_uses_rt = 1;
    idex_RegWr = 1; idex_DataRead = 1; idex_wsel = 5'h1f;
    exmem_RegWr = 1; exmem_DataRead = 1; exmem_DataWrite = 1; exmem_wsel = 5'h1f;
    ex_mispredict = 1; memwb_Halt = 1;
    for (int i = 0; i < 2; i++) begin
      #4;
      checkModel();
      checkOutput("reset_pc_en", 32'(pc_en), 32'd0);
      checkOutput("reset_flush", 32'({ifid_flush, idex_flush}), 32'd3);
      endCycle();
    end

    // Idle fetch after release.
    clearInputs();
    ihit = 1;
    #4;
    checkModel();
    checkOutput("post_reset_count", stall_count, 32'd0);
    endCycle();

    // Data miss for three cycles, icache hit only in the first one.
    exmem_DataRead = 1; dhit = 0; ihit = 1;
    stepCycle();
    ihit = 0;
    stepCycle();
    stepCycle();
    dhit = 1;
    #4;
    checkModel();
    checkOutput("dmiss_release_pc", 32'(pc_en), 32'd1);
    checkOutput("dmiss_release_cnt", stall_count, 32'd3);
    endCycle();

    // Load-use on rs, then the same with destination register zero.
    clearInputs();
    ihit = 1; idex_DataRead = 1; idex_wsel = 5'd5; ifid_rs = 5'd5;
    #4;
    checkModel();
    checkOutput("lduse_stall", 32'(stall), 32'd1);
    endCycle();
    idex_wsel = 5'd0; ifid_rs = 5'd0;
    #4;
    checkModel();
    checkOutput("lduse_r0_pc", 32'(pc_en), 32'd1);
    endCycle();

    // Forwarding priority, then MEM|WB forwarding alone.
    clearInputs();
    ihit = 1; idex_RegWr = 1; idex_wsel = 5'd8; exmem_RegWr = 1; exmem_wsel = 5'd8;
    ifid_rs = 5'd8; ifid_rt = 5'd8;
    #4;
    checkModel();
    checkOutput("fwd_ex_pair", 32'({fwd_exmem_a, fwd_exmem_b, fwd_memwb_a, fwd_memwb_b}), 32'hC);
    endCycle();
    idex_RegWr = 0;
    #4;
    checkModel();
    checkOutput("fwd_mem_pair", 32'({fwd_exmem_a, fwd_exmem_b, fwd_memwb_a, fwd_memwb_b}), 32'h3);
    endCycle();

    // Mispredict with a simultaneous load-use hazard.
    clearInputs();
    ex_mispredict = 1; idex_DataRead = 1; idex_wsel = 5'd3; ifid_rt = 5'd3; ifid_uses_rt = 1;
    #4;
    checkModel();
    checkOutput("misp_lduse", 32'({stall, pc_en, ifid_flush, idex_flush}), 32'b000111);
    endCycle();

    // Deferred mispredict under a data miss, and lduse with a fetch miss.
    clearInputs();
    ex_mispredict = 1; exmem_DataWrite = 1;
    stepCycle();
    dhit = 1;
    stepCycle();
    clearInputs();
    idex_DataRead = 1; idex_wsel = 5'd2; ifid_rs = 5'd2;
    stepCycle();

    // Randomized traffic with occasional resets and halts.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'b1, 1'b1);
      stepCycle();
    end

    // Halt sequence: one halt cycle, twenty random cycles, then reset.
    clearInputs();
    RST = 1;
    stepCycle();
    clearInputs();
    ihit = 1; memwb_Halt = 1;
    stepCycle();
    frozenCount = mCount;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b1);
      #4;
      checkModel();
      checkOutput("halt_locked", 32'({halted, pc_en, stall}), 32'b1_0_011);
      checkOutput("halt_count", stall_count, 32'(frozenCount));
      endCycle();
    end
    clearInputs();
    RST = 1;
    stepCycle();
    clearInputs();
    ihit = 1;
    #4;
    checkModel();
    checkOutput("run_after_halt", 32'({halted, pc_en}), 32'b01);
    endCycle();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
